// File: rtl/aes_pkg.sv
// Shared AES definitions: state geometry, FIPS-197 byte addressing and the
// InvSubBytes sequencer state encoding.
package aes_pkg;

  localparam int AES_BYTES   = 16;
  localparam int AES_STATE_W = 128;
  localparam int AES_IDX_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } inv_sub_state_t;

  // Byte k of a state lives at [127-8k -: 8]; byte 0 is the most significant.
  function automatic logic [7:0] byte_of(input logic [AES_STATE_W-1:0] state,
                                         input logic [AES_IDX_W-1:0]   k);
    return state[AES_STATE_W-1-8*k -: 8];
  endfunction

endpackage

// File: rtl/aes_inv_subbytes_seq_if.sv
// Upstream/downstream valid-ready bundle of the InvSubBytes sequencer.
// master = the side that offers states and consumes results; slave = the sequencer.
interface aes_inv_subbytes_seq_if;
  import aes_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [AES_STATE_W-1:0] in_state;
  logic                   out_valid;
  logic                   out_ready;
  logic [AES_STATE_W-1:0] out_state;

  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state
  );

endinterface

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box (FIPS-197 Figure 14), one byte in, one byte out.
// The table is packed row-major: entry 0x00 occupies the top byte.
module aes_inv_sbox (
  input  logic [7:0] in,
  output logic [7:0] out
);

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign out = INV_SBOX[2047-8*in -: 8];

endmodule

// File: rtl/aes_inv_subbytes_seq.sv
// InvSubBytes over a 128-bit state using LANES shared inverse S-boxes,
// stepping through the state in BEATS = 16/LANES beats, results written back in place.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | empty, in_ready=1, waiting for a state
//   BUSY  | substituting LANES bytes per cycle, cnt selects the byte group
//   DONE  | result on out_state with out_valid=1; retire may overlap next accept
module aes_inv_subbytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  aes_inv_subbytes_seq_if.slave  bus,
  output logic                   busy
);

  localparam int BEATS = AES_BYTES / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("aes_inv_subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  inv_sub_state_t         state;
  logic [CNT_W-1:0]       cnt;
  logic [AES_STATE_W-1:0] work;
  logic [AES_STATE_W-1:0] work_nxt;
  logic                   out_valid_q;
  logic                   busy_q;

  logic [AES_IDX_W-1:0]   lane_idx [LANES];
  logic [7:0]             sb_in    [LANES];
  logic [7:0]             sb_out   [LANES];

  // Lane l of beat cnt handles byte cnt*LANES + l; S-boxes are shared across beats.
  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign lane_idx[l] = AES_IDX_W'(int'(cnt) * LANES + l);
      assign sb_in[l]    = byte_of(work, lane_idx[l]);
      aes_inv_sbox u_sbox (
        .in  (sb_in[l]),
        .out (sb_out[l])
      );
    end
  endgenerate

  // Work register with the current beat's bytes replaced by their substitutes.
  always_comb begin
    work_nxt = work;
    for (int l = 0; l < LANES; l++) begin
      work_nxt[AES_STATE_W-1-8*int'(lane_idx[l]) -: 8] = sb_out[l];
    end
  end

  // Sequencer FSM; flush beats every handshake, the work register is left as is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      work        <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (flush) begin
      state       <= IDLE;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            work   <= bus.in_state;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= BUSY;
          end
        end
        BUSY: begin
          work <= work_nxt;
          if (cnt == CNT_W'(BEATS - 1)) begin
            cnt         <= '0;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (bus.in_valid) begin
              // Retire and accept in the same cycle: no bubble between blocks.
              work  <= bus.in_state;
              cnt   <= '0;
              state <= BUSY;
            end else begin
              busy_q <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        default: begin
          state       <= IDLE;
          cnt         <= '0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // A DONE block frees its slot exactly when downstream takes the result.
  assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.out_state = work;
  assign busy          = busy_q;

endmodule
